// File: rtl/axis_upsize_pkt.sv
// AXI-Stream width upconverter: packs EXPAND narrow beats into one wide word,
// closing short words on s_tlast and flagging populated lanes on m_tkeep.
module axis_upsize_pkt #(
    parameter int WIDTH     = 8,
    parameter int EXPAND    = 2,
    parameter int LSB_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [EXPAND*WIDTH-1:0] m_tdata,
    output logic [EXPAND-1:0]       m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready
);

    localparam int DW = EXPAND * WIDTH;
    localparam int CW = (EXPAND > 2) ? $clog2(EXPAND) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(EXPAND - 1);

    logic [CW-1:0]     cnt_q, cnt_d, lane;
    logic [DW-1:0]     acc_q, acc_d, merged;
    logic [EXPAND-1:0] mask_q, mask_d, mask_merged;
    logic [DW-1:0]     tdata_q, tdata_d;
    logic [EXPAND-1:0] keep_q, keep_d;
    logic              last_q, last_d;
    logic              vld_q, vld_d;
    logic              accept, complete;

    // The output register may take a new word whenever it is empty or draining.
    assign s_tready = !vld_q || m_tready;

    always_comb begin
        accept   = s_tvalid && s_tready;
        complete = accept && ((cnt_q == CNT_MAX) || s_tlast);
        lane     = (LSB_FIRST != 0) ? cnt_q : (CNT_MAX - cnt_q);

        merged      = acc_q;
        mask_merged = mask_q;
        for (int j = 0; j < EXPAND; j++) begin
            if (lane == CW'(j)) begin
                merged[j*WIDTH +: WIDTH] = s_tdata;
                mask_merged[j]           = 1'b1;
            end
        end

        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        tdata_d = tdata_q;
        keep_d  = keep_q;
        last_d  = last_q;
        vld_d   = vld_q;

        if (vld_q && m_tready) begin
            vld_d = 1'b0;
        end

        // A completing beat overrides the drain so back-to-back words keep m_tvalid high.
        if (complete) begin
            tdata_d = merged;
            keep_d  = mask_merged;
            last_d  = s_tlast;
            vld_d   = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            mask_d  = '0;
        end else if (accept) begin
            cnt_d  = cnt_q + CW'(1);
            acc_d  = merged;
            mask_d = mask_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
            tdata_q <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            tdata_q <= tdata_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tkeep  = keep_q;
    assign m_tlast  = last_q;
    assign m_tvalid = vld_q;

endmodule

// File: tb/tb_axis_upsize_pkt.sv
// Scoreboard bench for axis_upsize_pkt: three configurations (8x4 LSB, 8x4 MSB, 16x3 LSB)
// driven by directed and random traffic, checked against a beat-list reference model.
module tb_axis_upsize_pkt;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    localparam int WW [3] = '{8, 8, 16};
    localparam int EE [3] = '{4, 4, 3};
    localparam int LL [3] = '{1, 0, 1};

    logic [15:0] sd [3];
    logic        sv [3], sl [3], mr [3];
    logic [63:0] md [3];
    logic [7:0]  mk [3];
    logic        ml [3], mv [3], sr [3];

    logic [31:0] a_d, b_d;
    logic [47:0] c_d;
    logic [3:0]  a_k, b_k;
    logic [2:0]  c_k;
    logic        a_l, b_l, c_l, a_v, b_v, c_v, a_r, b_r, c_r;

    axis_upsize_pkt #(.WIDTH(8), .EXPAND(4), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .s_tdata(sd[0][7:0]), .s_tvalid(sv[0]), .s_tlast(sl[0]),
        .s_tready(a_r), .m_tdata(a_d), .m_tkeep(a_k), .m_tlast(a_l), .m_tvalid(a_v),
        .m_tready(mr[0]));
    axis_upsize_pkt #(.WIDTH(8), .EXPAND(4), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .s_tdata(sd[1][7:0]), .s_tvalid(sv[1]), .s_tlast(sl[1]),
        .s_tready(b_r), .m_tdata(b_d), .m_tkeep(b_k), .m_tlast(b_l), .m_tvalid(b_v),
        .m_tready(mr[1]));
    axis_upsize_pkt #(.WIDTH(16), .EXPAND(3), .LSB_FIRST(1)) dut_c (
        .clk(clk), .rst(rst), .s_tdata(sd[2]), .s_tvalid(sv[2]), .s_tlast(sl[2]),
        .s_tready(c_r), .m_tdata(c_d), .m_tkeep(c_k), .m_tlast(c_l), .m_tvalid(c_v),
        .m_tready(mr[2]));

    always_comb begin
        md[0] = {32'b0, a_d}; mk[0] = {4'b0, a_k}; ml[0] = a_l; mv[0] = a_v; sr[0] = a_r;
        md[1] = {32'b0, b_d}; mk[1] = {4'b0, b_k}; ml[1] = b_l; mv[1] = b_v; sr[1] = b_r;
        md[2] = {16'b0, c_d}; mk[2] = {5'b0, c_k}; ml[2] = c_l; mv[2] = c_v; sr[2] = c_r;
    end

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } exp_t;

    exp_t        q0 [$], q1 [$], q2 [$];
    logic [15:0] pend [3][8];
    int          pn [3];
    exp_t        hd [3];
    logic        hv [3];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    function automatic void check(input string name, input logic [72:0] act, input logic [72:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Reference: place the collected beats of one word into their lanes.
    function automatic exp_t mk_word(input int i, input logic last);
        exp_t e;
        int   lane;
        e = '0;
        for (int k = 0; k < pn[i]; k++) begin
            lane   = (LL[i] != 0) ? k : EE[i] - 1 - k;
            e.d    = e.d | (64'(pend[i][k]) << (lane * WW[i]));
            e.k[lane] = 1'b1;
        end
        e.l = last;
        return e;
    endfunction

    function automatic void push(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: outputs are checked first, then accepted beats feed the model.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                hv[i] = 1'b0;
                pn[i] = 0;
            end else begin
                check($sformatf("sb%0d s_tready", i), 73'(sr[i]), 73'(!mv[i] || mr[i]));
                if (hv[i] && mv[i])
                    check($sformatf("sb%0d stall stable", i), hd[i], {md[i], mk[i], ml[i]});
                if (mv[i] && mr[i]) begin
                    if (qsize(i) == 0) begin
                        total_cnt++;
                        $display("FAIL sb%0d unexpected word: got %h expected none", i, md[i]);
                    end else begin
                        e = pop(i);
                        check($sformatf("sb%0d word", i), {md[i], mk[i], ml[i]}, e);
                    end
                end
                hv[i] = mv[i] && !mr[i];
                hd[i] = {md[i], mk[i], ml[i]};
                if (sv[i] && sr[i]) begin
                    pend[i][pn[i]] = sd[i] & 16'((32'd1 << WW[i]) - 1);
                    pn[i]++;
                    if (sl[i] || pn[i] == EE[i]) begin
                        push(i, mk_word(i, sl[i]));
                        pn[i] = 0;
                    end
                end
            end
        end
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the beat.
    task automatic send(input int i, input logic [15:0] d, input logic l);
        int n;
        n = 0;
        sd[i] = d; sv[i] = 1'b1; sl[i] = l;
        @(negedge clk);
        while (!sr[i] && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 1000) begin
            total_cnt++;
            $display("FAIL send%0d timeout: got no s_tready expected acceptance", i);
        end
        @(posedge clk); #1;
        sv[i] = 1'b0; sl[i] = 1'b0;
    endtask

    task automatic chk_word(input string name, input int i, input logic [63:0] d,
                            input logic [7:0] k, input logic l);
        check({name, " valid"}, 73'(mv[i]), 73'(1'b1));
        check({name, " data"}, 73'(md[i]), 73'(d));
        check({name, " keep"}, 73'(mk[i]), 73'(k));
        check({name, " last"}, 73'(ml[i]), 73'(l));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent, n;
        logic acc;
        for (int i = 0; i < 3; i++) begin
            sd[i] = '0; sv[i] = 1'b0; sl[i] = 1'b0; mr[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d valid", i), 73'(mv[i]), 73'(0));
            check($sformatf("rst%0d data", i), 73'(md[i]), 73'(0));
            check($sformatf("rst%0d keep", i), 73'(mk[i]), 73'(0));
            check($sformatf("rst%0d last", i), 73'(ml[i]), 73'(0));
        end

        send(0, 16'h11, 1'b0); send(0, 16'h22, 1'b0); send(0, 16'h33, 1'b0);
        check("t1 not yet valid", 73'(mv[0]), 73'(0));
        send(0, 16'h44, 1'b0);
        chk_word("t1", 0, 64'h44332211, 8'hF, 1'b0);

        send(0, 16'hAA, 1'b0); send(0, 16'hBB, 1'b1);
        chk_word("t2 short", 0, 64'h0000BBAA, 8'h3, 1'b1);
        send(0, 16'hCC, 1'b0); send(0, 16'hDD, 1'b0); send(0, 16'hEE, 1'b0); send(0, 16'hFF, 1'b0);
        chk_word("t2 full", 0, 64'hFFEEDDCC, 8'hF, 1'b0);

        send(1, 16'h11, 1'b0); send(1, 16'h22, 1'b0); send(1, 16'h33, 1'b0); send(1, 16'h44, 1'b0);
        chk_word("t3 msb", 1, 64'h11223344, 8'hF, 1'b0);
        send(1, 16'hAA, 1'b1);
        chk_word("t3 single", 1, 64'hAA000000, 8'h8, 1'b1);

        check("t5 cnt0", 73'(dut_c.cnt_q), 73'(0));
        send(2, 16'h0001, 1'b0);
        check("t5 cnt1", 73'(dut_c.cnt_q), 73'(1));
        send(2, 16'h0002, 1'b0);
        check("t5 cnt2", 73'(dut_c.cnt_q), 73'(2));
        send(2, 16'h0003, 1'b0);
        check("t5 cnt wrap", 73'(dut_c.cnt_q), 73'(0));
        chk_word("t5 w1", 2, 64'h000300020001, 8'h7, 1'b0);
        send(2, 16'h0004, 1'b0); send(2, 16'h0005, 1'b0); send(2, 16'h0006, 1'b0);
        chk_word("t5 w2", 2, 64'h000600050004, 8'h7, 1'b0);

        mr[0] = 1'b0;
        send(0, 16'h5A, 1'b0); send(0, 16'h6B, 1'b0); send(0, 16'h7C, 1'b0); send(0, 16'h8D, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("t4 stall s_tready", 73'(sr[0]), 73'(0));
            check("t4 stall data", 73'(md[0]), 73'(64'h8D7C6B5A));
            check("t4 stall valid", 73'(mv[0]), 73'(1));
        end
        @(posedge clk); #1;
        mr[0] = 1'b1;

        sent = 0;
        n = 0;
        while ((sent < 10000 || sv[0]) && n < 60000) begin
            n++;
            @(negedge clk);
            acc = sv[0] && sr[0];
            @(posedge clk); #1;
            mr[0] = ($urandom_range(0, 2) != 0);
            if (!sv[0] || acc) begin
                if (sent < 10000 && $urandom_range(0, 3) != 0) begin
                    sv[0] = 1'b1;
                    sd[0] = 16'($urandom);
                    sl[0] = ($urandom_range(0, 5) == 0) || (sent == 9999);
                    sent++;
                end else begin
                    sv[0] = 1'b0;
                    sl[0] = 1'b0;
                end
            end
        end
        sv[0] = 1'b0; sl[0] = 1'b0; mr[0] = 1'b1;
        n = 0;
        while ((q0.size() != 0 || mv[0]) && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("t4 random drained", 73'(q0.size()), 73'(0));

        send(0, 16'h77, 1'b0); send(0, 16'h88, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6 rst valid", 73'(mv[0]), 73'(0));
        check("t6 rst data", 73'(md[0]), 73'(0));
        check("t6 rst keep", 73'(mk[0]), 73'(0));
        check("t6 rst last", 73'(ml[0]), 73'(0));
        send(0, 16'h01, 1'b0); send(0, 16'h02, 1'b0); send(0, 16'h03, 1'b0); send(0, 16'h04, 1'b0);
        chk_word("t6 clean", 0, 64'h04030201, 8'hF, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("end queues empty", 73'(q0.size() + q1.size() + q2.size()), 73'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
